// File: rtl/shift_add_mult_pkg.sv
// -----------------------------------------------------------------------------
// shift_add_mult_pkg
// Shared types and helpers for the shift-add multiplier.
//   state_t   : controller states (IDLE, RUN, FINISH)
//   cnt_width : bit width of a step counter able to hold 0..width
// -----------------------------------------------------------------------------
package shift_add_mult_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_mult_addsub.sv
// -----------------------------------------------------------------------------
// shift_add_mult_addsub
// WIDTH+1-bit adder (adder/subtractor when SHIFT_ADD_MULT_SIGNED_EN is defined)
// used for the per-step partial-product update.
// Ports:
//   a, b  : WIDTH-bit operands (accumulator upper half, gated multiplicand)
//   sext  : (signed build only) sign-extend both operands to WIDTH+1 bits
//   sub   : (signed build only) compute a - b instead of a + b
//   sum   : low WIDTH bits of the WIDTH+1-bit result
//   cout  : bit WIDTH of the result (carry in unsigned use, sign when signed)
// Configuration macro: SHIFT_ADD_MULT_SIGNED_EN
// -----------------------------------------------------------------------------
module shift_add_mult_addsub
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SHIFT_ADD_MULT_SIGNED_EN
  input  logic             sext,
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] result;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic [WIDTH:0] ax;
  logic [WIDTH:0] bx;

  always_comb begin
    ax     = {sext & a[WIDTH-1], a};
    bx     = {sext & b[WIDTH-1], b};
    result = sub ? (ax - bx) : (ax + bx);
  end
`else
  always_comb begin
    result = {1'b0, a} + {1'b0, b};
  end
`endif

  assign {cout, sum} = result;

endmodule

// File: rtl/shift_add_mult.sv
// -----------------------------------------------------------------------------
// shift_add_mult
// Sequential shift-and-add multiplier, one partial product per clock.
// A START accepted while READY=1 captures A/B; WIDTH edges later P holds the
// 2*WIDTH-bit product and DONE pulses for one cycle. A START seen in FINISH
// is accepted immediately (back-to-back, no idle gap). START is ignored in RUN.
// Ports:
//   CK     : clock, rising edge
//   RSTN   : asynchronous active-low reset (aborts any multiply, P cleared)
//   START  : multiply request, sampled only while READY=1
//   A, B   : multiplicand / multiplier, captured on the accepting edge
//   SIGNED : (signed build only) treat operands as two's complement
//   P      : last completed product, registered
//   READY  : idle or finishing, able to accept START
//   DONE   : single-cycle completion pulse
// Configuration macro: SHIFT_ADD_MULT_SIGNED_EN (adds SIGNED port and the
// subtract path; undefined gives an unsigned-only multiplier).
// -----------------------------------------------------------------------------
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 CK,
  input  logic                 RSTN,
  input  logic                 START,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
`ifdef SHIFT_ADD_MULT_SIGNED_EN
  input  logic                 SIGNED,
`endif
  output logic [2*WIDTH-1:0]   P,
  output logic                 READY,
  output logic                 DONE
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("shift_add_mult: WIDTH=%0d outside legal range 2..32", WIDTH);
  end

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] mcand;   // captured multiplicand
  logic [WIDTH-1:0] hi;      // accumulator upper half
  logic [WIDTH-1:0] lo;      // multiplier, shifted out as product bits shift in
  logic [CW-1:0]    cnt;     // completed steps

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             last;

  assign last   = (cnt == LAST);
  assign addend = lo[0] ? mcand : '0;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic sgn;
  logic sub;

  // Two's-complement multiplier: the MSB of B carries weight -2^(WIDTH-1),
  // so the final step subtracts instead of adding.
  assign sub = sgn & last;

  shift_add_mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (hi),
    .b    (addend),
    .sext (sgn),
    .sub  (sub),
    .sum  (sum),
    .cout (cout)
  );
`else
  shift_add_mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (hi),
    .b    (addend),
    .sum  (sum),
    .cout (cout)
  );
`endif

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      P     <= '0;
      DONE  <= 1'b0;
      READY <= 1'b1;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
      sgn   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, FINISH: begin
          DONE <= 1'b0;
          if (START) begin
            mcand <= A;
            lo    <= B;
            hi    <= '0;
            cnt   <= '0;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
            sgn   <= SIGNED;
`endif
            READY <= 1'b0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // {cout, sum} is the WIDTH+1-bit step result; shifting it right
          // together with lo moves one finished product bit into lo.
          hi  <= {cout, sum[WIDTH-1:1]};
          lo  <= {sum[0], lo[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (last) begin
            P     <= {cout, sum, lo[WIDTH-1:1]};
            DONE  <= 1'b1;
            READY <= 1'b1;
            state <= FINISH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;

  logic        CK = 1'b0;
  logic        RSTN;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic        ready4, done4, ready8, done8;
  logic        mode_s = 1'b0;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic        sg4, sg8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CK = ~CK;

  shift_add_mult #(.WIDTH(4)) dut4 (
    .CK(CK), .RSTN(RSTN), .START(start4), .A(a4), .B(b4),
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    .SIGNED(sg4),
`endif
    .P(p4), .READY(ready4), .DONE(done4)
  );

  shift_add_mult #(.WIDTH(8)) dut8 (
    .CK(CK), .RSTN(RSTN), .START(start8), .A(a8), .B(b8),
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    .SIGNED(sg8),
`endif
    .P(p8), .READY(ready8), .DONE(done8)
  );

  // Reference: plain integer multiplication, truncated to the product width.
  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int x, y;
    if (s) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'({28'd0, a});
      y = int'({28'd0, b});
    end
    return 8'(x * y);
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x, y;
    if (s) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'({24'd0, a});
      y = int'({24'd0, b});
    end
    return 16'(x * y);
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b);
    a4 = a; b4 = b; start4 = 1'b1;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    sg4 = mode_s;
`endif
    @(negedge CK);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    sg4 = 1'($urandom);
`endif
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    a8 = a; b8 = b; start8 = 1'b1;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    sg8 = mode_s;
`endif
    @(negedge CK);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    sg8 = 1'($urandom);
`endif
  endtask

  // Bounded wait for DONE; lat counts edges after the accepting edge.
  task automatic wait_done4(output int lat, output int rdy_low);
    lat = 0; rdy_low = 0;
    while (done4 !== 1'b1 && lat < 40) begin
      if (ready4 === 1'b0) rdy_low++;
      @(negedge CK); lat++;
    end
  endtask

  task automatic wait_done8(output int lat, output int rdy_low);
    lat = 0; rdy_low = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (ready8 === 1'b0) rdy_low++;
      @(negedge CK); lat++;
    end
  endtask

  task automatic test_reset();
    checks++; if (p4 !== 8'h00) begin errors++; $display("FAIL reset_p4 got %h want 00", p4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done4 got %b want 0", done4); end
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready4 got %b want 1", ready4); end
    checks++; if (p8 !== 16'h0000) begin errors++; $display("FAIL reset_p8 got %h want 0000", p8); end
    RSTN = 1'b1;
    @(negedge CK);
    checks++; if (ready4 !== 1'b1 || done4 !== 1'b0) begin errors++; $display("FAIL post_reset_idle got ready=%b done=%b want 1 0", ready4, done4); end
  endtask

  task automatic test_max();
    int lat, rl;
    issue4(4'd15, 4'd15);
    wait_done4(lat, rl);
    checks++; if (lat !== 4) begin errors++; $display("FAIL max_latency got %0d want 4", lat); end
    checks++; if (rl !== 4) begin errors++; $display("FAIL max_ready_low got %0d want 4", rl); end
    checks++; if (p4 !== 8'hE1) begin errors++; $display("FAIL max_product got %h want e1", p4); end
    @(negedge CK);
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL max_done_single got %b want 0", done4); end
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL max_ready_after got %b want 1", ready4); end
    checks++; if (p4 !== 8'hE1) begin errors++; $display("FAIL max_p_stable got %h want e1", p4); end
  endtask

  task automatic test_back_to_back();
    int lat, rl;
    a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
    @(negedge CK);
    a4 = 4'd0; b4 = 4'd9;
    wait_done4(lat, rl);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_lat1 got %0d want 4", lat); end
    checks++; if (p4 !== 8'h8F) begin errors++; $display("FAIL b2b_p1 got %h want 8f", p4); end
    @(negedge CK);
    checks++; if (ready4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL b2b_no_gap got ready=%b done=%b want 0 0", ready4, done4); end
    checks++; if (p4 !== 8'h8F) begin errors++; $display("FAIL b2b_p1_hold got %h want 8f", p4); end
    start4 = 1'b0; a4 = 4'd7; b4 = 4'd7;
    wait_done4(lat, rl);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_lat2 got %0d want 4", lat); end
    checks++; if (p4 !== 8'h00) begin errors++; $display("FAIL b2b_p2 got %h want 00", p4); end
    @(negedge CK);
  endtask

  task automatic test_start_ignored();
    int ndone, first;
    logic [7:0] pd;
    ndone = 0; first = -1; pd = 8'hxx;
    issue4(4'd6, 4'd7);
    for (int i = 0; i < 12; i++) begin
      if (done4 === 1'b1) begin
        ndone++; pd = p4;
        if (first < 0) first = i;
      end
      start4 = (i == 0); a4 = 4'd1; b4 = 4'd1;
      @(negedge CK);
    end
    start4 = 1'b0;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", ndone); end
    checks++; if (first !== 4) begin errors++; $display("FAIL ign_latency got %0d want 4", first); end
    checks++; if (pd !== 8'h2A) begin errors++; $display("FAIL ign_product got %h want 2a", pd); end
    checks++; if (p4 !== 8'h2A) begin errors++; $display("FAIL ign_p_hold got %h want 2a", p4); end
  endtask

  task automatic test_reset_abort();
    int ndone, lat, rl;
    ndone = 0;
    issue4(4'd9, 4'd5);
    @(negedge CK);
    @(negedge CK);
    RSTN = 1'b0;
    #1;
    checks++; if (p4 !== 8'h00) begin errors++; $display("FAIL abort_p got %h want 00", p4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done4); end
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", ready4); end
    @(negedge CK);
    RSTN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (done4 === 1'b1) ndone++;
      @(negedge CK);
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", ndone); end
    issue4(4'd3, 4'd3);
    wait_done4(lat, rl);
    checks++; if (lat !== 4) begin errors++; $display("FAIL abort_next_lat got %0d want 4", lat); end
    checks++; if (p4 !== 8'h09) begin errors++; $display("FAIL abort_next_p got %h want 09", p4); end
    @(negedge CK);
  endtask

  task automatic test_width8();
    int lat, rl;
    issue8(8'hFF, 8'hFF);
    wait_done8(lat, rl);
    checks++; if (lat !== 8) begin errors++; $display("FAIL w8_latency got %0d want 8", lat); end
    checks++; if (rl !== 8) begin errors++; $display("FAIL w8_ready_low got %0d want 8", rl); end
    checks++; if (p8 !== 16'hFE01) begin errors++; $display("FAIL w8_product got %h want fe01", p8); end
    @(negedge CK);
  endtask

  task automatic test_random();
    int lat, rl;
    logic [3:0] a, b;
    logic [7:0] c, d;
    for (int n = 0; n < 25; n++) begin
`ifdef SHIFT_ADD_MULT_SIGNED_EN
      mode_s = 1'($urandom);
`endif
      a = 4'($urandom); b = 4'($urandom);
      issue4(a, b);
      wait_done4(lat, rl);
      checks++; if (lat !== 4 || p4 !== ref4(a, b, mode_s)) begin errors++; $display("FAIL rnd4 a=%h b=%h s=%b got p=%h lat=%0d want p=%h lat=4", a, b, mode_s, p4, lat, ref4(a, b, mode_s)); end
      repeat ($urandom_range(0, 2)) @(negedge CK);
    end
    for (int n = 0; n < 10; n++) begin
`ifdef SHIFT_ADD_MULT_SIGNED_EN
      mode_s = 1'($urandom);
`endif
      c = 8'($urandom); d = 8'($urandom);
      issue8(c, d);
      wait_done8(lat, rl);
      checks++; if (lat !== 8 || p8 !== ref8(c, d, mode_s)) begin errors++; $display("FAIL rnd8 a=%h b=%h s=%b got p=%h lat=%0d want p=%h lat=8", c, d, mode_s, p8, lat, ref8(c, d, mode_s)); end
      @(negedge CK);
    end
    mode_s = 1'b0;
  endtask

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  task automatic test_signed();
    int lat, rl;
    logic [3:0] av [3];
    logic [3:0] bv [3];
    logic [7:0] pv [3];
    av[0] = 4'h8; bv[0] = 4'h8; pv[0] = 8'h40;
    av[1] = 4'h8; bv[1] = 4'h7; pv[1] = 8'hC8;
    av[2] = 4'h3; bv[2] = 4'hF; pv[2] = 8'hFD;
    mode_s = 1'b1;
    for (int n = 0; n < 3; n++) begin
      issue4(av[n], bv[n]);
      wait_done4(lat, rl);
      checks++; if (lat !== 4 || p4 !== pv[n]) begin errors++; $display("FAIL signed_%0d got p=%h lat=%0d want p=%h lat=4", n, p4, lat, pv[n]); end
      @(negedge CK);
    end
    mode_s = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    sg4 = 1'b0; sg8 = 1'b0;
`endif
    repeat (2) @(negedge CK);
    test_reset();
    test_max();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    test_width8();
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
